// File: rtl/cmd_pkg.sv
// Shared instruction-format definitions for the command encoder and the instruction decoder:
// code types, modes, opcodes, and word-count and legality helpers.
package cmd_pkg;

    localparam logic [2:0] CODE_TYPE_INT = 3'b000;
    localparam logic [2:0] CODE_TYPE_REG = 3'b001;
    localparam logic [2:0] CODE_TYPE_IMM = 3'b010;
    localparam logic [2:0] CODE_TYPE_JMP = 3'b100;
    localparam logic [2:0] CODE_TYPE_CTL = 3'b111;

    localparam logic CODE_MODE_USR = 1'b0;
    localparam logic CODE_MODE_ADM = 1'b1;

    localparam int CODE_OPCD_HLT = 0;
    localparam int CODE_OPCD_ADD = 1;
    localparam int CODE_OPCD_SUB = 2;
    localparam int CODE_OPCD_SJF = 3;

    // Stream words per command; 0 marks a code type with no defined format.
    function automatic logic [1:0] code_word_count(input logic [2:0] code_type);
        case (code_type)
            CODE_TYPE_CTL, CODE_TYPE_INT: code_word_count = 2'd1;
            CODE_TYPE_JMP:                code_word_count = 2'd2;
            CODE_TYPE_REG, CODE_TYPE_IMM: code_word_count = 2'd3;
            default:                      code_word_count = 2'd0;
        endcase
    endfunction

    // Control commands are reserved for admin mode.
    function automatic logic code_is_legal(input logic admin_flag, input logic [2:0] code_type);
        case (code_type)
            CODE_TYPE_INT, CODE_TYPE_REG,
            CODE_TYPE_IMM, CODE_TYPE_JMP: code_is_legal = 1'b1;
            CODE_TYPE_CTL:                code_is_legal = (admin_flag == CODE_MODE_ADM);
            default:                      code_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_encoder.sv
// Serializes one command into a 1-3 word instruction stream (header, opdata0, opdata1).
// Define CMD_ENCODER_PIPE_EN to accept the next command during the final word (zero-bubble streams).
module cmd_encoder
    import cmd_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_admin_flag,
    input  logic [2:0]           cmd_code_type,
    input  logic [BUS_WIDTH-5:0] cmd_opcode,
    input  logic [BUS_WIDTH-1:0] cmd_opdata0,
    input  logic [BUS_WIDTH-1:0] cmd_opdata1,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 encoder_error
);

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_HEAD  = 5'b00010,
        ST_OP0   = 5'b00100,
        ST_OP1   = 5'b01000,
        ST_ERROR = 5'b10000
    } state_t;

    state_t                 state, state_nxt;
    logic                   admin_q;
    logic [2:0]             type_q;
    logic [BUS_WIDTH-5:0]   opcode_q;
    logic [BUS_WIDTH-1:0]   op0_q, op1_q;
    logic [1:0]             word_count;
    logic                   accept;

    assign word_count = code_word_count(type_q);
    assign accept     = cmd_valid && cmd_ready;

`ifdef CMD_ENCODER_PIPE_EN
    logic last_word;
    assign last_word = (state == ST_HEAD && word_count == 2'd1) ||
                       (state == ST_OP0  && word_count == 2'd2) ||
                       (state == ST_OP1);
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        cmd_ready     = 1'b0;
        out_valid     = 1'b0;
        data_out      = '0;
        encoder_error = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = code_is_legal(cmd_admin_flag, cmd_code_type) ? ST_HEAD : ST_ERROR;
            end
            ST_HEAD: begin
                out_valid = 1'b1;
                data_out  = {admin_q, type_q, opcode_q};
                if (out_ready)
                    state_nxt = (word_count == 2'd1) ? ST_IDLE : ST_OP0;
            end
            ST_OP0: begin
                out_valid = 1'b1;
                data_out  = op0_q;
                if (out_ready)
                    state_nxt = (word_count == 2'd2) ? ST_IDLE : ST_OP1;
            end
            ST_OP1: begin
                out_valid = 1'b1;
                data_out  = op1_q;
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
            ST_ERROR: encoder_error = 1'b1;
            default:  state_nxt = ST_IDLE;
        endcase
`ifdef CMD_ENCODER_PIPE_EN
        // The final word and the next command hand off in the same cycle.
        if (last_word && out_ready) begin
            cmd_ready = 1'b1;
            if (cmd_valid)
                state_nxt = code_is_legal(cmd_admin_flag, cmd_code_type) ? ST_HEAD : ST_ERROR;
        end
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_IDLE;
            // NOTE: the command registers are reset too, so a dropped command leaves nothing stale behind.
            admin_q  <= 1'b0;
            type_q   <= '0;
            opcode_q <= '0;
            op0_q    <= '0;
            op1_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (accept) begin
                admin_q  <= cmd_admin_flag;
                type_q   <= cmd_code_type;
                opcode_q <= cmd_opcode;
                op0_q    <= cmd_opdata0;
                op1_q    <= cmd_opdata1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: directed scenarios plus randomized commands checked
// against a word-queue reference model.
module tb_cmd_encoder;

    localparam int BW = 32;
`ifdef CMD_ENCODER_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_admin_flag = 1'b0;
    logic [2:0]    cmd_code_type = '0;
    logic [BW-5:0] cmd_opcode = '0;
    logic [BW-1:0] cmd_opdata0 = '0;
    logic [BW-1:0] cmd_opdata1 = '0;
    logic [BW-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          encoder_error;

    cmd_encoder #(.BUS_WIDTH(BW)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_admin_flag (cmd_admin_flag),
        .cmd_code_type  (cmd_code_type),
        .cmd_opcode     (cmd_opcode),
        .cmd_opdata0    (cmd_opdata0),
        .cmd_opdata1    (cmd_opdata1),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .encoder_error  (encoder_error)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    // Reference model: words still owed to the stream, the sticky error, and a log of sent words.
    logic [31:0] exp_q[$];
    bit          m_err = 1'b0;
    bit          acc_seen = 1'b0;
    logic [31:0] log_word[$];
    int          log_cyc[$];

    function automatic bit legal_cmd(input bit adm, input logic [2:0] t);
        return (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || (t == 3'd7 && adm));
    endfunction

    function automatic int n_words(input logic [2:0] t);
        if (t == 3'd7 || t == 3'd0) return 1;
        if (t == 3'd4) return 2;
        return 3;
    endfunction

    always @(negedge clk) begin : monitor
        bit          exp_rdy;
        logic [31:0] head;
        acc_seen = 1'b0;
        if (!nreset) begin
            exp_q.delete();
            m_err = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_data_out", data_out, 0);
            check("rst_error", encoder_error, 0);
        end else begin
            exp_rdy = !m_err && (exp_q.size() == 0 || (PIPE && exp_q.size() == 1 && out_ready));
            check("out_valid", out_valid, exp_q.size() > 0);
            check("data_out", data_out, exp_q.size() > 0 ? exp_q[0] : 32'h0);
            check("cmd_ready", cmd_ready, exp_rdy);
            check("encoder_error", encoder_error, m_err);
            if (exp_q.size() > 0 && out_ready) begin
                log_word.push_back(data_out);
                log_cyc.push_back(cycle);
                void'(exp_q.pop_front());
            end
            if (cmd_valid && exp_rdy) begin
                acc_seen = 1'b1;
                if (legal_cmd(cmd_admin_flag, cmd_code_type)) begin
                    head = (32'(cmd_admin_flag) << 31) + (32'(cmd_code_type) << 28) + 32'(cmd_opcode);
                    exp_q.push_back(head);
                    if (n_words(cmd_code_type) >= 2) exp_q.push_back(cmd_opdata0);
                    if (n_words(cmd_code_type) == 3) exp_q.push_back(cmd_opdata1);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit adm, input logic [2:0] t, input logic [27:0] opc,
                        input logic [31:0] o0, input logic [31:0] o1);
        bit done = 1'b0;
        cmd_valid      = 1'b1;
        cmd_admin_flag = adm;
        cmd_code_type  = t;
        cmd_opcode     = opc;
        cmd_opdata0    = o0;
        cmd_opdata1    = o1;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (acc_seen) done = 1'b1;
        end
        cmd_valid = 1'b0;
        check("accept_in_time", done, 1);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        nreset    = 1'b0;
        tick();
        nreset    = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s;
        int c_acc;
        int errw;
        logic [2:0] legal_types [5];
        legal_types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7};

        repeat (2) tick();
        nreset = 1'b1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_data_out", data_out, 0);
        check("reset_error", encoder_error, 0);

        // REG ADD, three consecutive words starting the cycle after acceptance.
        out_ready = 1'b1;
        s = log_word.size();
        send(1'b0, 3'b001, 28'd1, 32'd5, 32'd7);
        c_acc = cycle;
        repeat (5) tick();
        check("reg_count", log_word.size() - s, 3);
        if (log_word.size() - s == 3) begin
            check("reg_w0", log_word[s], 32'h10000001);
            check("reg_w1", log_word[s+1], 32'h00000005);
            check("reg_w2", log_word[s+2], 32'h00000007);
            check("reg_latency", log_cyc[s], c_acc);
            check("reg_consec", log_cyc[s+2] - log_cyc[s], 2);
        end
        check("reg_idle_ready", cmd_ready, 1);

        // Admin CTL HLT, then the same command in user mode.
        s = log_word.size();
        send(1'b1, 3'b111, 28'd0, 32'd0, 32'd0);
        repeat (3) tick();
        check("ctl_count", log_word.size() - s, 1);
        if (log_word.size() > s) check("ctl_w0", log_word[s], 32'hF0000000);
        s = log_word.size();
        send(1'b0, 3'b111, 28'd0, 32'd0, 32'd0);
        repeat (4) tick();
        check("ctl_usr_error", encoder_error, 1);
        check("ctl_usr_ready", cmd_ready, 0);
        check("ctl_usr_nowords", log_word.size() - s, 0);
        do_reset();

        // JMP SJF with backpressure 1,0,0,1.
        s = log_word.size();
        send(1'b0, 3'b100, 28'd3, 32'd3, 32'd0);
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        check("jmp_stall_data", data_out, 32'h00000003);
        tick();
        check("jmp_stall_data2", data_out, 32'h00000003);
        out_ready = 1'b1; tick();
        repeat (2) tick();
        check("jmp_count", log_word.size() - s, 2);
        if (log_word.size() - s == 2) begin
            check("jmp_w0", log_word[s], 32'h40000003);
            check("jmp_w1", log_word[s+1], 32'h00000003);
            check("jmp_gap", log_cyc[s+1] - log_cyc[s], 3);
        end

        // Illegal type, reset recovery, then a normal IMM command.
        send(1'b0, 3'b011, 28'd9, 32'd1, 32'd2);
        repeat (2) tick();
        check("t011_error", encoder_error, 1);
        do_reset();
        check("t011_cleared", encoder_error, 0);
        check("t011_ready", cmd_ready, 1);
        s = log_word.size();
        send(1'b0, 3'b010, 28'd2, 32'hDEAD, 32'hBEEF);
        repeat (4) tick();
        check("imm_count", log_word.size() - s, 3);
        if (log_word.size() - s == 3) begin
            check("imm_w0", log_word[s], 32'h20000002);
            check("imm_w1", log_word[s+1], 32'h0000DEAD);
            check("imm_w2", log_word[s+2], 32'h0000BEEF);
        end

        // Reset during OP0 drops the rest of the command.
        s = log_word.size();
        send(1'b0, 3'b010, 28'd5, 32'd11, 32'd22);
        tick();
        nreset = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_data_out", data_out, 0);
        tick();
        nreset = 1'b1;
        repeat (5) tick();
        check("abort_leftover", log_word.size() - s, 1);

        // Two INT commands back to back.
        s = log_word.size();
        send(1'b0, 3'b000, 28'h2A, 32'd0, 32'd0);
        send(1'b1, 3'b000, 28'hB, 32'd0, 32'd0);
        repeat (4) tick();
        check("b2b_count", log_word.size() - s, 2);
        if (log_word.size() - s == 2) begin
            check("b2b_w0", log_word[s], 32'h0000002A);
            check("b2b_w1", log_word[s+1], 32'h8000000B);
            check("b2b_gap", log_cyc[s+1] - log_cyc[s], PIPE ? 1 : 2);
        end

        // Randomized traffic with backpressure, illegal commands and occasional resets.
        errw = 0;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (m_err) errw++;
            if (!nreset) begin
                nreset = 1'b1;
            end else if ((m_err && errw > 3) || $urandom_range(0, 199) == 0) begin
                nreset    = 1'b0;
                cmd_valid = 1'b0;
                errw      = 0;
            end else if (!cmd_valid || acc_seen) begin
                cmd_valid      = ($urandom_range(0, 1) == 1);
                cmd_admin_flag = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) < 8)
                    cmd_code_type = legal_types[$urandom_range(0, 4)];
                else
                    cmd_code_type = 3'($urandom_range(0, 7));
                cmd_opcode  = 28'($urandom);
                cmd_opdata0 = $urandom;
                cmd_opdata1 = $urandom;
            end
            tick();
        end
        cmd_valid = 1'b0;
        nreset    = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        check("final_drained", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
